stage_ifetch_queue: RTL
=======================

// Module: stage_ifetch_queue
// PURPOSE
//  Instruction fetch stage with a DEPTH-entry prefetch queue and redirect/flush.
//  Owns the fetch PC and streams sequential addresses to synchronous instruction memory.
//  Tags each opcode with its address and hands opcodes to decode over a drdy/ack_in handshake.
//  Accepts a same-cycle redirect from the branch ('[' / ']') resolution logic.
// PARAMETERS
//  A_WIDTH   12  instruction address width
//  D_WIDTH   8   opcode width
//  DEPTH     4   prefetch queue entries; power of two, >= 2
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk          in   1        clock, all state on posedge
//  reset        in   1        synchronous, active-high
//  redirect     in   1        flush queue and restart fetch at redirect_pc
//  redirect_pc  in   A_WIDTH  new fetch address, valid when redirect=1
//  ice          out  1        instruction memory read enable
//  ia           out  A_WIDTH  instruction memory address
//  id           in   D_WIDTH  read data, valid the cycle after ice=1
//  opcode       out  D_WIDTH  head-of-queue opcode, 0 when drdy=0
//  opcode_pc    out  A_WIDTH  address of opcode, 0 when drdy=0
//  drdy         out  1        queue non-empty
//  ack_in       in   1        decode consumes head this cycle (only meaningful with drdy=1)
//  level        out  log2(DEPTH)+1  queued entry count
// BEHAVIOUR
//  Reset: count=0, inflight=0, fetch_pc=RESET_PC; drdy=0, level=0, opcode=0, opcode_pc=0.
//   ice=0 while reset=1. Reset mid-operation discards queue and any in-flight read.
//  Memory timing: ice=1 in cycle N -> id sampled at the posedge ending N+1.
//   Entry is visible (drdy=1) in N+2. Min first-opcode latency after reset release: 2 cycles.
//  pop  = drdy & ack_in & !redirect.
//  push = inflight & !redirect. The data written is id; the tag is the address issued with it.
//  Issue rule (no redirect): ice = (count + inflight - pop) < DEPTH.
//   ia = fetch_pc; on issue fetch_pc <= fetch_pc+1, wrapping mod 2^A_WIDTH.
//   inflight <= ice, and the issued address is held in inflight_pc.
//  Redirect, same cycle:
//   - count <= 0; any in-flight id is discarded and never enters the queue.
//   - ice=1, ia=redirect_pc; fetch_pc <= redirect_pc+1; inflight <= 1.
//   - ack_in is ignored in this cycle (flush wins).
//  Simultaneous push and pop: count unchanged, head advances, tail advances.
//  Full (count==DEPTH): no issue; drdy stays 1; the in-flight slot was reserved by the issue rule, so no overflow.
//  Empty: drdy=0; ack_in has no effect.
//  Steady state with ack_in held 1: one opcode per cycle, no bubbles.
//  Throughput is never throttled below 1/cycle while count+inflight < DEPTH.
//  Redirect and reset both high: reset wins.
//  Ring pointers are log2(DEPTH) bits and wrap naturally. count is a separate log2(DEPTH)+1 bit counter.
// STRUCTURE
//  Shared defines (bf_defs.vh): A_WIDTH/D_WIDTH defaults, opcode encodings.
//  Sub-module fetch_fifo: sync FIFO, storing {pc,opcode} in DEPTH entries, with flush and push/pop/count.
//  Top level: fetch_pc, inflight/inflight_pc, issue logic, redirect muxing.
// TESTING
//  1. Reset release, ack_in=0, memory[i]=i+8'h10.
//     -> ia=0,1,2,3 in cycles 0-3, then ice=0. level=4. opcode=8'h10, opcode_pc=0.
//  2. ack_in=1 continuously from reset.
//     -> drdy from cycle 2; opcode_pc=0,1,2,... one per cycle, no gaps.
//  3. Queue full (level=4), assert ack_in one cycle.
//     -> same cycle ice=1, ia=4; level 3 then back to 4 two cycles later.
//  4. redirect=1, redirect_pc=12'h100 with 3 queued and 1 in flight.
//     -> next cycle level=0, drdy=0. Next opcode_pc=12'h100 two cycles after redirect, then 12'h101.
//  5. fetch_pc=12'hFFF, ack_in=1.
//     -> opcode_pc sequence 12'hFFF, 12'h000; no stall.
//  6. reset pulsed with queue half full and inflight=1.
//     -> all outputs 0 the following cycle; stale id never appears at opcode.

Source files
------------

// File: rtl/stage_ifetch_queue_pkg.sv
// Shared defaults and opcode encodings for the instruction fetch stage.
package stage_ifetch_queue_pkg;

  localparam int A_WIDTH_DEF  = 12;
  localparam int D_WIDTH_DEF  = 8;
  localparam int DEPTH_DEF    = 4;
  localparam int RESET_PC_DEF = 0;

  // Opcode encodings as they appear in instruction memory.
  typedef enum logic [7:0] {
    OP_INC   = 8'h2B,
    OP_DEC   = 8'h2D,
    OP_LEFT  = 8'h3C,
    OP_RIGHT = 8'h3E,
    OP_OUT   = 8'h2E,
    OP_IN    = 8'h2C,
    OP_JZ    = 8'h5B,
    OP_JNZ   = 8'h5D
  } opcode_e;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stage_ifetch_queue_if.sv
// Fetch stage bus: instruction memory port, decode handshake and redirect.
// master = the fetch stage, slave = memory/decode/branch side.
interface stage_ifetch_queue_if
  import stage_ifetch_queue_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF
);
  localparam int LW = cnt_width(DEPTH);

  logic               redirect;
  logic [A_WIDTH-1:0] redirect_pc;
  logic               ice;
  logic [A_WIDTH-1:0] ia;
  logic [D_WIDTH-1:0] id;
  logic [D_WIDTH-1:0] opcode;
  logic [A_WIDTH-1:0] opcode_pc;
  logic               drdy;
  logic               ack_in;
  logic [LW-1:0]      level;

  modport master (
    input  redirect, redirect_pc, id, ack_in,
    output ice, ia, opcode, opcode_pc, drdy, level
  );

  modport slave (
    output redirect, redirect_pc, id, ack_in,
    input  ice, ia, opcode, opcode_pc, drdy, level
  );

endinterface

// File: rtl/stage_ifetch_queue_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, opcode} words with flush.
// Head is read combinationally so an entry written at a posedge is
// visible at the head in the very next cycle.
module stage_ifetch_queue_fifo
  import stage_ifetch_queue_pkg::*;
#(
  parameter int W     = A_WIDTH_DEF + D_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push,
  input  logic [W-1:0]                push_data,
  input  logic                        pop,
  output logic [W-1:0]                head_data,
  output logic [cnt_width(DEPTH)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;

  // Storage write; the pointers decide whether the word is ever seen.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  // Ring pointers and occupancy; flush and reset empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (!push && pop) count_reg <= count_reg - CW'(1);
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/stage_ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues sequential reads to
// synchronous instruction memory and queues tagged opcodes for decode.
module stage_ifetch_queue
  import stage_ifetch_queue_pkg::*;
#(
  parameter int A_WIDTH  = A_WIDTH_DEF,
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  stage_ifetch_queue_if.master bus
);
  localparam int                 CW         = cnt_width(DEPTH);
  localparam logic [A_WIDTH-1:0] RESET_PC_V = A_WIDTH'(RESET_PC);
  localparam logic [CW:0]        DEPTH_V    = (CW+1)'(DEPTH);

  logic [A_WIDTH-1:0]         fetch_pc_reg, fetch_pc_next;
  logic                       inflight_reg;
  logic [A_WIDTH-1:0]         inflight_pc_reg;
  logic [A_WIDTH-1:0]         ia_mux;
  logic                       issue, push, pop, drdy;
  logic [CW:0]                pending;
  logic [CW-1:0]              count;
  logic [A_WIDTH+D_WIDTH-1:0] head_data;

  // Issue decision: redirect restarts at redirect_pc, otherwise issue only
  // while the queue plus the outstanding read still leaves a free slot.
  always_comb begin
    drdy          = (count != '0);
    pop           = drdy & bus.ack_in & ~bus.redirect & ~reset;
    push          = inflight_reg & ~bus.redirect & ~reset;
    pending       = {1'b0, count} + {{CW{1'b0}}, inflight_reg} - {{CW{1'b0}}, pop};
    issue         = 1'b0;
    ia_mux        = fetch_pc_reg;
    fetch_pc_next = fetch_pc_reg;
    if (reset) begin
      issue = 1'b0;
    end else if (bus.redirect) begin
      issue         = 1'b1;
      ia_mux        = bus.redirect_pc;
      fetch_pc_next = bus.redirect_pc + A_WIDTH'(1);
    end else if (pending < DEPTH_V) begin
      issue         = 1'b1;
      fetch_pc_next = fetch_pc_reg + A_WIDTH'(1);
    end
  end

  // Fetch PC and the single outstanding memory read it is waiting on.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC_V;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      inflight_reg <= issue;
      if (issue) inflight_pc_reg <= ia_mux;
    end
  end

  stage_ifetch_queue_fifo #(
    .W     (A_WIDTH + D_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect),
    .push      (push),
    .push_data ({inflight_pc_reg, bus.id}),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  assign bus.ice       = issue;
  assign bus.ia        = ia_mux;
  assign bus.drdy      = drdy;
  assign bus.level     = count;
  assign bus.opcode    = drdy ? head_data[D_WIDTH-1:0] : '0;
  assign bus.opcode_pc = drdy ? head_data[A_WIDTH+D_WIDTH-1:D_WIDTH] : '0;

endmodule
